// File: rtl/conflict_detector_mc_pkg.sv
// conflict_detector_mc_pkg: shared parameters and types for the multi-lane conflict detector
package conflict_detector_mc_pkg;
  localparam int NUM_VARS = 512;
  localparam int VAR_BITS = $clog2(NUM_VARS);
  localparam int NUM_LANES = 2;
  localparam int LEVEL_BITS = 8;
  typedef struct packed {
    logic val;
    logic valid;
    logic [LEVEL_BITS-1:0] level;
  } var_info_t;
  typedef struct packed {
    logic [VAR_BITS-1:0] idx;
    logic val;
  } lit_t;
  typedef enum logic {ACTIVE, CONFLICT} cd_state_e;
endpackage

// File: rtl/conflict_detector_mc_if.sv
// conflict_detector_mc_if: implication input, backtrack control and Imply Stack output bundle
interface conflict_detector_mc_if;
  import conflict_detector_mc_pkg::*;
  logic [NUM_LANES-1:0] in_valid;
  logic [NUM_LANES*VAR_BITS-1:0] in_var;
  logic [NUM_LANES-1:0] in_val;
  logic in_ready;
  logic [LEVEL_BITS-1:0] cur_level;
  logic bt_en;
  logic [LEVEL_BITS-1:0] bt_level;
  logic conflict;
  logic [VAR_BITS-1:0] conflict_var;
  logic [NUM_LANES-1:0] out_valid;
  logic [NUM_LANES*VAR_BITS-1:0] out_var;
  logic [NUM_LANES-1:0] out_val;
  logic out_ready;
  modport slave (
    input in_valid, in_var, in_val, cur_level, bt_en, bt_level, out_ready,
    output in_ready, conflict, conflict_var, out_valid, out_var, out_val
  );
  modport master (
    output in_valid, in_var, in_val, cur_level, bt_en, bt_level, out_ready,
    input in_ready, conflict, conflict_var, out_valid, out_var, out_val
  );
endinterface

// File: rtl/conflict_detector_mc_lane_check.sv
// cd_lane_check: one lane's conflict/duplicate verdict against memory and lower lanes of the beat
module cd_lane_check
  import conflict_detector_mc_pkg::*;
#(
  parameter int L = 0
) (
  input  logic [NUM_LANES-1:0] valid_i,
  input  lit_t [NUM_LANES-1:0] lit_i,
  input  logic                 mem_valid_i,
  input  logic                 mem_val_i,
  output logic                 conf_o,
  output logic                 dup_o
);
  // lower lanes act like assignments already made earlier in the same beat
  always_comb begin
    conf_o = valid_i[L] && mem_valid_i && (mem_val_i != lit_i[L].val);
    dup_o = valid_i[L] && mem_valid_i && (mem_val_i == lit_i[L].val);
    for (int k = 0; k < L; k++) begin
      if (valid_i[k] && valid_i[L] && lit_i[k].idx == lit_i[L].idx) begin
        conf_o = conf_o || (lit_i[k].val != lit_i[L].val);
        dup_o = dup_o || (lit_i[k].val == lit_i[L].val);
      end
    end
  end
endmodule

// File: rtl/conflict_detector_mc.sv
// conflict_detector_mc: multi-lane implication conflict checker; CD_DUP_FILTER_EN suppresses duplicate pushes
module conflict_detector_mc
  import conflict_detector_mc_pkg::*;
(
  input logic clock,
  input logic reset,
  conflict_detector_mc_if.slave bus
);
`ifdef CD_DUP_FILTER_EN
  localparam bit DUP_FILTER = 1'b1;
`else
  localparam bit DUP_FILTER = 1'b0;
`endif
  lit_t [NUM_LANES-1:0] lit;
  var_info_t mem_q [NUM_VARS];
  cd_state_e state_q, state_d;
  logic [NUM_LANES-1:0] conf, dup, push;
  logic accept, any_conf;
  logic [VAR_BITS-1:0] low_var;
  logic conflict_q, conflict_d;
  logic [VAR_BITS-1:0] cvar_q, cvar_d;
  logic [NUM_LANES-1:0] ov_q, ov_d, oval_q, oval_d;
  logic [NUM_LANES*VAR_BITS-1:0] ovar_q, ovar_d;
  // unpack the lane buses and pick the lowest conflicting lane's variable
  always_comb begin
    low_var = '0;
    for (int l = 0; l < NUM_LANES; l++) lit[l] = {bus.in_var[l*VAR_BITS +: VAR_BITS], bus.in_val[l]};
    for (int l = NUM_LANES - 1; l >= 0; l--) if (conf[l]) low_var = lit[l].idx;
  end
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    cd_lane_check #(.L(l)) u_chk (
      .valid_i    (bus.in_valid),
      .lit_i      (lit),
      .mem_valid_i(mem_q[lit[l].idx].valid),
      .mem_val_i  (mem_q[lit[l].idx].val),
      .conf_o     (conf[l]),
      .dup_o      (dup[l])
    );
  end
  assign bus.in_ready = !reset && state_q == ACTIVE && !bus.bt_en && (!(|ov_q) || bus.out_ready);
  assign accept = bus.in_ready && |bus.in_valid;
  assign any_conf = |conf;
  assign push = bus.in_valid & ~(DUP_FILTER ? dup : '0);
  assign bus.conflict = conflict_q;
  assign bus.conflict_var = cvar_q;
  assign bus.out_valid = ov_q;
  assign bus.out_var = ovar_q;
  assign bus.out_val = oval_q;
  // state register
  always_ff @(posedge clock) state_q <= reset ? ACTIVE : state_d;
  // next state and output register loads; backtrack outranks any beat
  always_comb begin
    state_d = state_q;
    conflict_d = conflict_q;
    cvar_d = cvar_q;
    ov_d = ov_q;
    ovar_d = ovar_q;
    oval_d = oval_q;
    if (bus.bt_en) begin
      state_d = ACTIVE;
      conflict_d = 1'b0;
      ov_d = '0;
    end else if (accept && any_conf) begin
      state_d = CONFLICT;
      conflict_d = 1'b1;
      cvar_d = low_var;
      ov_d = '0;
    end else if (accept) begin
      ov_d = push;
      ovar_d = bus.in_var;
      oval_d = bus.in_val;
    end else if (bus.out_ready) begin
      ov_d = '0;
    end
  end
  // conflict flag and output register
  always_ff @(posedge clock) begin
    if (reset) begin
      conflict_q <= 1'b0;
      cvar_q <= '0;
      ov_q <= '0;
      ovar_q <= '0;
      oval_q <= '0;
    end else begin
      conflict_q <= conflict_d;
      cvar_q <= cvar_d;
      ov_q <= ov_d;
      ovar_q <= ovar_d;
      oval_q <= oval_d;
    end
  end
  // assignment memory: level-based invalidate on backtrack, lane writes only on clean beats
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int v = 0; v < NUM_VARS; v++) mem_q[v] <= '0;
    end else if (bus.bt_en) begin
      for (int v = 0; v < NUM_VARS; v++) if (mem_q[v].level > bus.bt_level) mem_q[v].valid <= 1'b0;
    end else if (accept && !any_conf) begin
      for (int l = 0; l < NUM_LANES; l++) if (bus.in_valid[l]) mem_q[lit[l].idx] <= '{val: lit[l].val, valid: 1'b1, level: bus.cur_level};
    end
  end
endmodule

// File: tb/tb_conflict_detector_mc.sv
// tb_conflict_detector_mc: directed vectors checked by a per-cycle assignment-table model plus literal expectations
module tb_conflict_detector_mc;
  import conflict_detector_mc_pkg::*;
`ifdef CD_DUP_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  conflict_detector_mc_if bus ();
  conflict_detector_mc dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;
  bit m_set [NUM_VARS];
  bit m_bit [NUM_VARS];
  int m_lvl [NUM_VARS];
  bit m_inconf;
  int m_cvar;
  bit [NUM_LANES-1:0] m_push;
  int m_pvar [NUM_LANES];
  bit m_pval [NUM_LANES];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int lane_var(int l);
    logic [NUM_LANES*VAR_BITS-1:0] v;
    v = bus.in_var;
    return int'(v[l*VAR_BITS +: VAR_BITS]);
  endfunction
  function automatic bit m_ready();
    return !reset && !m_inconf && !bus.bt_en && (m_push == 0 || bus.out_ready);
  endfunction
  // advance the model by one clock from the inputs present at the edge
  task automatic step();
    int bad;
    bit dupl;
    bad = -1;
    if (reset) begin
      foreach (m_set[v]) m_set[v] = 0;
      m_inconf = 0;
      m_cvar = 0;
      m_push = 0;
    end else if (bus.bt_en) begin
      foreach (m_set[v]) if (m_lvl[v] > int'(bus.bt_level)) m_set[v] = 0;
      m_push = 0;
      m_inconf = 0;
    end else if (m_ready() && bus.in_valid != 0) begin
      for (int l = NUM_LANES - 1; l >= 0; l--) begin
        if (!bus.in_valid[l]) continue;
        if (m_set[lane_var(l)] && m_bit[lane_var(l)] != bus.in_val[l]) bad = l;
        for (int k = 0; k < l; k++)
          if (bus.in_valid[k] && lane_var(k) == lane_var(l) && bus.in_val[k] != bus.in_val[l]) bad = l;
      end
      if (bad >= 0) begin
        m_inconf = 1;
        m_cvar = lane_var(bad);
        m_push = 0;
      end else begin
        m_push = 0;
        for (int l = 0; l < NUM_LANES; l++) begin
          if (!bus.in_valid[l]) continue;
          dupl = m_set[lane_var(l)];
          for (int k = 0; k < l; k++) if (bus.in_valid[k] && lane_var(k) == lane_var(l)) dupl = 1;
          m_push[l] = !(FILT && dupl);
          m_pvar[l] = lane_var(l);
          m_pval[l] = bus.in_val[l];
        end
        for (int l = 0; l < NUM_LANES; l++) if (bus.in_valid[l]) begin
          m_set[lane_var(l)] = 1;
          m_bit[lane_var(l)] = bus.in_val[l];
          m_lvl[lane_var(l)] = int'(bus.cur_level);
        end
      end
    end else if (bus.out_ready) begin
      m_push = 0;
    end
  endtask
  // every cycle: update model at the edge, compare outputs just after it
  always begin
    @(posedge clock);
    step();
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(m_ready()));
    chk("conflict", 32'(bus.conflict), 32'(m_inconf));
    if (m_inconf) chk("conflict_var", 32'(bus.conflict_var), 32'(m_cvar));
    chk("out_valid", 32'(bus.out_valid), 32'(m_push));
    for (int l = 0; l < NUM_LANES; l++) if (m_push[l]) begin
      chk("out_var", 32'(bus.out_var[l*VAR_BITS +: VAR_BITS]), 32'(m_pvar[l]));
      chk("out_val", 32'(bus.out_val[l]), 32'(m_pval[l]));
    end
  end
  task automatic tick(int n = 1);
    repeat (n) @(negedge clock);
  endtask
  task automatic put(bit v0, int a0, bit b0, bit v1, int a1, bit b1);
    bus.in_valid = {v1, v0};
    bus.in_var = {VAR_BITS'(a1), VAR_BITS'(a0)};
    bus.in_val = {b1, b0};
  endtask
  task automatic backtrack(int lvl);
    bus.bt_en = 1'b1;
    bus.bt_level = LEVEL_BITS'(lvl);
    tick();
    bus.bt_en = 1'b0;
  endtask
  initial begin
    put(0, 0, 0, 0, 0, 0);
    bus.cur_level = '0;
    bus.bt_en = 1'b0;
    bus.bt_level = '0;
    bus.out_ready = 1'b1;
    tick(2);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_conflict", 32'(bus.conflict), 0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", 32'(bus.in_ready), 1);
    bus.cur_level = 8'd1;
    put(1, 5, 1, 0, 0, 0);
    tick();
    chk("t1_out_valid", 32'(bus.out_valid), 1);
    chk("t1_out_var0", 32'(bus.out_var[VAR_BITS-1:0]), 5);
    put(0, 0, 0, 0, 0, 0);
    tick();
    put(1, 5, 0, 0, 0, 0);
    tick();
    chk("t1_conflict", 32'(bus.conflict), 1);
    chk("t1_conflict_var", 32'(bus.conflict_var), 5);
    put(0, 0, 0, 0, 0, 0);
    backtrack(0);
    chk("t1_bt_clear", 32'(bus.conflict), 0);
    bus.cur_level = 8'd0;
    put(1, 7, 1, 1, 7, 0);
    tick();
    chk("t2_conflict", 32'(bus.conflict), 1);
    chk("t2_conflict_var", 32'(bus.conflict_var), 7);
    put(0, 0, 0, 0, 0, 0);
    backtrack(255);
    put(1, 7, 0, 0, 0, 0);
    tick();
    chk("t2_unwritten", 32'(bus.conflict), 0);
    chk("t2_unwritten_push", 32'(bus.out_valid), 1);
    bus.cur_level = 8'd1;
    put(1, 3, 1, 0, 0, 0);
    tick();
    bus.cur_level = 8'd2;
    put(1, 4, 0, 0, 0, 0);
    tick();
    put(0, 0, 0, 0, 0, 0);
    backtrack(1);
    put(1, 4, 1, 0, 0, 0);
    tick();
    chk("t3_var4_clean", 32'(bus.conflict), 0);
    chk("t3_var4_val", 32'(bus.out_val[0]), 1);
    put(1, 3, 0, 0, 0, 0);
    tick();
    chk("t3_var3_conflict", 32'(bus.conflict), 1);
    chk("t3_conflict_var", 32'(bus.conflict_var), 3);
    put(0, 0, 0, 0, 0, 0);
    backtrack(0);
    bus.cur_level = 8'd3;
    bus.out_ready = 1'b0;
    put(1, 20, 1, 1, 21, 0);
    tick();
    put(1, 22, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_ready", 32'(bus.in_ready), 0);
      chk("t4_stall_valid", 32'(bus.out_valid), 3);
      chk("t4_stall_var", 32'(bus.out_var), 32'((21 << VAR_BITS) | 20));
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t4_resume_valid", 32'(bus.out_valid), 1);
    chk("t4_resume_var", 32'(bus.out_var[VAR_BITS-1:0]), 22);
    put(0, 0, 0, 0, 0, 0);
    tick();
    put(1, 20, 0, 0, 0, 0);
    tick();
    chk("t5_conflict_var", 32'(bus.conflict_var), 20);
    put(1, 30, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_ready", 32'(bus.in_ready), 0);
      tick();
    end
    backtrack(255);
    chk("t5_bt_conflict", 32'(bus.conflict), 0);
    put(0, 0, 0, 0, 0, 0);
    tick();
    put(1, 30, 0, 0, 0, 0);
    tick();
    chk("t5_var30_clean", 32'(bus.conflict), 0);
    put(1, 9, 1, 1, 9, 1);
    tick();
    chk("t6_dup_beat", 32'(bus.out_valid), FILT ? 1 : 3);
    put(1, 9, 1, 0, 0, 0);
    tick();
    chk("t6_dup_mem", 32'(bus.out_valid), FILT ? 0 : 1);
    put(0, 0, 0, 1, 40, 1);
    tick();
    chk("t6_lane1_only", 32'(bus.out_valid), 2);
    chk("t6_lane1_var", 32'(bus.out_var[2*VAR_BITS-1:VAR_BITS]), 40);
    put(0, 0, 0, 0, 0, 0);
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
